// File: rtl/ifns_pkg.sv
// Shared types and elaboration-time weight helpers for the iterative IFNS decoder.
// Weight rule: digit i weighs F(i), except the top digit which weighs F(n+1).
package ifns_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  function automatic longint unsigned fib(input int n);
    longint unsigned a, b, t;
    a = 0;
    b = 1;
    for (int k = 1; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic longint unsigned ifns_weight(input int n, input int i);
    return (i == n) ? fib(n + 1) : fib(i);
  endfunction

  // Smallest width holding the maximum sum 2*F(n+1)-1.
  function automatic int ifns_acc_width(input int n);
    longint unsigned lim;
    int w;
    lim = 2 * fib(n + 1);
    w = 0;
    for (int k = 0; k < 63; k++)
      if ((64'd1 << k) < lim) w = k + 1;
    return w;
  endfunction

endpackage

// File: rtl/ifns_chunk_sum.sv
// Weighted sum of one DPC-digit chunk starting at 0-based digit BASE.
// Digits past N_BITS (padding in the last chunk) carry weight zero.
module ifns_chunk_sum
  import ifns_pkg::*;
#(
  parameter int N_BITS = 33,
  parameter int BASE   = 0,
  parameter int DPC    = 4,
  parameter int AW     = 24
) (
  input  logic [DPC-1:0] dig,
  output logic [AW-1:0]  sum
);

  logic [DPC-1:0][AW-1:0] term;

  for (genvar j = 0; j < DPC; j++) begin : g_term
    localparam logic [AW-1:0] W = (BASE + j < N_BITS) ? AW'(ifns_weight(N_BITS, BASE + j + 1)) : '0;
    assign term[j] = dig[j] ? W : '0;
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < DPC; j++) sum = sum + term[j];
  end

endmodule

// File: rtl/ifns_iter_decoder.sv
// Sequential IFNS (Fibonacci-weighted) decoder: accumulates DPC digits per cycle
// and returns the value mod 2^V_WIDTH plus an overflow flag over valid/ready.
module ifns_iter_decoder
  import ifns_pkg::*;
#(
  parameter int N_BITS  = 33,
  parameter int V_WIDTH = 23,
  parameter int DPC     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BITS-1:0]  in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [V_WIDTH-1:0] out_value,
  output logic               out_ovf
);

  localparam int AW  = ifns_acc_width(N_BITS);
  localparam int NCH = (N_BITS + DPC - 1) / DPC;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = NCH * DPC;

  state_e               state_q, state_d;
  logic [PW-1:0]        code_q, code_d;
  logic [AW-1:0]        acc_q, acc_d, acc_nxt, chunk_sum;
  logic [CW-1:0]        chunk_q, chunk_d;
  logic [V_WIDTH-1:0]   val_q, val_d;
  logic                 ovf_q, ovf_d;
  logic                 capture;
  logic [NCH-1:0][AW-1:0] part;

  // One constant-weight adder tree per chunk; the active one is picked by chunk_q.
  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    ifns_chunk_sum #(.N_BITS(N_BITS), .BASE(c * DPC), .DPC(DPC), .AW(AW)) u_chunk (
      .dig (code_q[c*DPC +: DPC]),
      .sum (part[c])
    );
  end

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign out_valid = (state_q == HOLD);
  assign out_value = val_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    chunk_sum = '0;
    for (int c = 0; c < NCH; c++)
      if (chunk_q == CW'(c)) chunk_sum = part[c];
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    acc_d   = acc_q;
    chunk_d = chunk_q;
    val_d   = val_q;
    ovf_d   = ovf_q;
    acc_nxt = acc_q + chunk_sum;
    capture = in_valid && in_ready;
    case (state_q)
      ACCUM: begin
        acc_d   = acc_nxt;
        chunk_d = chunk_q + 1'b1;
        if (chunk_q == CW'(NCH - 1)) begin
          state_d = HOLD;
          val_d   = V_WIDTH'(acc_nxt);
          ovf_d   = (acc_nxt >> V_WIDTH) != '0;
        end
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A capture in HOLD overrides the return to IDLE.
    if (capture) begin
      code_d  = PW'(in_code);
      acc_d   = '0;
      chunk_d = '0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      chunk_q <= chunk_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ifns_iter_decoder.sv
// Directed and back-to-back checks of ifns_iter_decoder, plus a small parameter sweep.
module tb_ifns_iter_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_value;
  logic        out_ovf;

  logic [3:0]  s_in_valid = '0;
  logic [3:0]  s_in_ready;
  logic [3:0]  s_out_valid;
  logic [3:0]  s_out_ready = '0;
  logic [3:0]  s_ovf;
  logic [22:0] s_val [3];
  logic [5:0]  s_val8;
  logic [32:0] s_code = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifns_iter_decoder #(.N_BITS(33), .V_WIDTH(23), .DPC(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_ovf(out_ovf)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    ifns_iter_decoder #(.N_BITS(33), .V_WIDTH(23), .DPC(g == 0 ? 1 : (g == 1 ? 3 : 33))) u_sw (
      .clk(clk), .rst(rst), .in_valid(s_in_valid[g]), .in_ready(s_in_ready[g]), .in_code(s_code),
      .out_valid(s_out_valid[g]), .out_ready(s_out_ready[g]), .out_value(s_val[g]), .out_ovf(s_ovf[g])
    );
  end

  ifns_iter_decoder #(.N_BITS(8), .V_WIDTH(6), .DPC(3)) u_sw8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid[3]), .in_ready(s_in_ready[3]), .in_code(s_code[7:0]),
    .out_valid(s_out_valid[3]), .out_ready(s_out_ready[3]), .out_value(s_val8), .out_ovf(s_ovf[3])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned m_fib(input int n);
    longint unsigned f [0:40];
    f[1] = 1;
    f[2] = 1;
    for (int k = 3; k <= 40; k++) f[k] = f[k-1] + f[k-2];
    return f[n];
  endfunction

  function automatic longint unsigned ref_sum(input int n, input logic [32:0] code);
    longint unsigned s;
    s = 0;
    for (int i = 1; i <= n; i++)
      if (code[i-1]) s += (i == n) ? m_fib(i + 1) : m_fib(i);
    return s;
  endfunction

  task automatic run_one(input logic [32:0] code, output int lat, output logic [22:0] v, output logic ovf);
    in_code  = code;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_code  = ~code;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    v   = out_value;
    ovf = out_ovf;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [22:0] v;
    logic        ovf;
    logic [32:0] dir_code [5];
    logic [63:0] dir_val  [5];
    logic [32:0] sw_code  [8];
    logic [32:0] bcode    [1000];
    int          exp_lat  [4];
    int          slat     [4];
    longint unsigned q [$];
    longint unsigned e, m;
    int got, k, cyc, last;

    // reset state
    rst = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_value", 64'(out_value), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // directed values, latency 9 at N=33/DPC=4
    dir_code[0] = 33'h0_0000_0001; dir_val[0] = 64'd1;
    dir_code[1] = 33'h1_0000_0000; dir_val[1] = 64'd5702887;
    dir_code[2] = 33'h0_FFFF_FFFF; dir_val[2] = 64'd5702886;
    dir_code[3] = 33'h1_FFFF_FFFF; dir_val[3] = 64'd3017165;
    dir_code[4] = 33'h0_0000_0000; dir_val[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      run_one(dir_code[i], lat, v, ovf);
      chk($sformatf("dir%0d_lat", i), 64'(lat), 64'd9);
      chk($sformatf("dir%0d_val", i), 64'(v), dir_val[i]);
      chk($sformatf("dir%0d_ovf", i), 64'(ovf), (i == 3) ? 64'd1 : 64'd0);
    end

    // result held under back-pressure; in_valid pulse must not be taken
    in_code  = 33'h0_0000_0055;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("hold_lat", 64'(lat), 64'd9);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_value", 64'(out_value), 64'd21);
      chk("hold_ovf", 64'(out_ovf), 64'd0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      if (i == 2) begin in_valid = 1'b1; in_code = 33'h0_0000_0002; end
      if (i == 3) in_valid = 1'b0;
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release_idle", 64'(in_ready), 64'd1);
    chk("hold_release_valid", 64'(out_valid), 64'd0);

    // reset in ACCUM cycle 4 beats a same-cycle in_valid
    in_code  = 33'h1_FFFF_FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("accum_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_code  = 33'h0_0000_0001;
    step();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    run_one(33'h0_0000_0010, lat, v, ovf);
    chk("after_abort_lat", 64'(lat), 64'd9);
    chk("after_abort_val", 64'(v), 64'd5);

    // back-to-back stream, one result every C+1 = 10 cycles
    for (int i = 0; i < 1000; i++) bcode[i] = {1'($urandom), 32'($urandom)};
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_code = bcode[0];
    k = 0; got = 0; cyc = 0; last = -1;
    while (got < 1000 && cyc < 20000) begin
      if (out_valid) begin
        if (q.size() == 0) chk("b2b_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("b2b_val", 64'(out_value), e % 64'd8388608);
          chk("b2b_ovf", 64'(out_ovf), 64'(e >= 64'd8388608));
        end
        if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'd10);
        last = cyc;
        got++;
      end
      if (in_ready && in_valid) begin
        q.push_back(ref_sum(33, in_code));
        k++;
      end
      step();
      cyc++;
      if (k < 1000) in_code = bcode[k];
      else in_valid = 1'b0;
    end
    chk("b2b_count", 64'(got), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    // parameter sweep: DPC 1/3/33 at N=33, and N=8/V=6/DPC=3
    exp_lat = '{33, 11, 1, 3};
    sw_code[0] = 33'h1_FFFF_FFFF;
    sw_code[1] = 33'h0_0000_0000;
    sw_code[2] = 33'h1_0000_0000;
    sw_code[3] = 33'h0_0000_0080;
    sw_code[4] = 33'h0_0000_00FF;
    for (int i = 5; i < 8; i++) sw_code[i] = {1'($urandom), 32'($urandom)};
    for (int i = 0; i < 8; i++) begin
      chk("sw_idle", 64'(s_in_ready), 64'hF);
      s_code = sw_code[i];
      s_in_valid = 4'hF;
      step();
      s_in_valid = 4'h0;
      s_code = ~sw_code[i];
      slat = '{0, 0, 0, 0};
      for (int c = 1; c <= 40; c++) begin
        step();
        for (int g = 0; g < 4; g++)
          if (s_out_valid[g] && slat[g] == 0) slat[g] = c;
      end
      for (int g = 0; g < 4; g++)
        chk($sformatf("sw%0d_lat_g%0d", i, g), 64'(slat[g]), 64'(exp_lat[g]));
      m = ref_sum(33, sw_code[i]);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("sw%0d_val_g%0d", i, g), 64'(s_val[g]), m % 64'd8388608);
        chk($sformatf("sw%0d_ovf_g%0d", i, g), 64'(s_ovf[g]), 64'(m >= 64'd8388608));
      end
      m = ref_sum(8, sw_code[i]);
      chk($sformatf("sw%0d_val_n8", i), 64'(s_val8), m % 64'd64);
      chk($sformatf("sw%0d_ovf_n8", i), 64'(s_ovf[3]), 64'(m >= 64'd64));
      s_out_ready = 4'hF;
      step();
      s_out_ready = 4'h0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
